alu_issue_ctrl: RTL and testbench

//  Issue/writeback stage wrapped around the combinational ALU.
//  - Accepts instruction words over a valid/ready handshake.
//  - Reads operands from a 4-entry register file and drives the ALU inputs from registers.
//  - Captures result and zero flag, writes the result back, and presents it downstream.
//  - Supplies every ALU input and consumes every ALU output, so it is the ALU's direct

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_regfile.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: opcodes, FSM encoding,
// and the instruction word layout.
package alu_pkg;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned RF_AW    = 2;
  localparam int unsigned RF_DEPTH = 4;
  localparam int unsigned INSTR_W  = 10;

  localparam logic [OP_W-1:0] OP_PASS = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
  localparam logic [OP_W-1:0] OP_INC  = 3'b011;
  localparam logic [OP_W-1:0] OP_AND  = 3'b100;
  localparam logic [OP_W-1:0] OP_OR   = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b110;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b111;

  localparam int unsigned OPC_MSB = 9;
  localparam int unsigned OPC_LSB = 7;
  localparam int unsigned CIN_BIT = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RA_MSB  = 3;
  localparam int unsigned RA_LSB  = 2;
  localparam int unsigned RB_MSB  = 1;
  localparam int unsigned RB_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Field order mirrors the bit positions above.
  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic             c_in;
    logic [RF_AW-1:0] rd;
    logic [RF_AW-1:0] ra;
    logic [RF_AW-1:0] rb;
  } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// 4-entry register file: two combinational read ports with load bypass,
// one write port where the ALU writeback beats a direct load.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             wb_en,
  input  logic [1:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [1:0]       ra_addr,
  input  logic [1:0]       rb_addr,
  output logic [WIDTH-1:0] ra_data_c,
  output logic [WIDTH-1:0] rb_data_c
);

  logic [RF_DEPTH-1:0][WIDTH-1:0] rf_q;
  logic [RF_DEPTH-1:0][WIDTH-1:0] rf_d;

  // Writeback applied last so it overrides a same-address load.
  always_comb begin
    rf_d = rf_q;
    if (ld_en) rf_d[ld_addr] = ld_data;
    if (wb_en) rf_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rf_q <= '0;
    else        rf_q <= rf_d;
  end

  assign ra_data_c = (ld_en && (ld_addr == ra_addr)) ? ld_data : rf_q[ra_addr];
  assign rb_data_c = (ld_en && (ld_addr == rb_addr)) ? ld_data : rf_q[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around an external combinational ALU:
// IDLE accepts and latches operands, EXEC captures the result, RESP hands it off.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned CNT_W = alu_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [9:0]       instr,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic [CNT_W-1:0] retired
);

  state_e state_q, state_d;
  instr_t instr_c;

  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic [2:0]       alu_opcode_q, alu_opcode_d;
  logic [1:0]       rd_q, rd_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_valid_q, res_valid_d;
  logic             instr_ready_q, instr_ready_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wb_en_c;
  logic [WIDTH-1:0] ra_data_c, rb_data_c;

  assign instr_c = instr_t'(instr);
  assign wb_en_c = (state_q == ST_EXEC);

  alu_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wb_en     (wb_en_c),
    .wb_addr   (rd_q),
    .wb_data   (alu_result),
    .ra_addr   (instr_c.ra),
    .rb_addr   (instr_c.rb),
    .ra_data_c (ra_data_c),
    .rb_data_c (rb_data_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are decoded from the next state so they are registered Moore outputs.
  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_cin_d     = alu_cin_q;
    alu_opcode_d  = alu_opcode_q;
    rd_d          = rd_q;
    res_data_d    = res_data_q;
    res_zero_d    = res_zero_q;
    retired_d     = retired_q;
    instr_ready_d = (state_d == ST_IDLE);
    res_valid_d   = (state_d == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          alu_a_d      = ra_data_c;
          alu_b_d      = rb_data_c;
          alu_cin_d    = instr_c.c_in;
          alu_opcode_d = instr_c.opcode;
          rd_d         = instr_c.rd;
        end
      end
      ST_EXEC: begin
        res_data_d = alu_result;
        res_zero_d = alu_zero;
      end
      ST_RESP: begin
        if (res_ready) retired_d = retired_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_cin_q     <= 1'b0;
      alu_opcode_q  <= '0;
      rd_q          <= '0;
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      instr_ready_q <= 1'b1;
      retired_q     <= '0;
    end else begin
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_cin_q     <= alu_cin_d;
      alu_opcode_q  <= alu_opcode_d;
      rd_q          <= rd_d;
      res_data_q    <= res_data_d;
      res_zero_q    <= res_zero_d;
      res_valid_q   <= res_valid_d;
      instr_ready_q <= instr_ready_d;
      retired_q     <= retired_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cin     = alu_cin_q;
  assign alu_opcode  = alu_opcode_q;
  assign res_data    = res_data_q;
  assign res_zero    = res_zero_q;
  assign res_valid   = res_valid_q;
  assign instr_ready = instr_ready_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU hooked to its ALU ports.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [9:0]    instr;
  logic          ld_en;
  logic [1:0]    ld_addr;
  logic [W-1:0]  ld_data;
  logic [W-1:0]  alu_a, alu_b;
  logic          alu_cin;
  logic [2:0]    alu_opcode;
  logic [W-1:0]  alu_result;
  logic          alu_zero;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_zero;
  logic [CW-1:0] retired;

  int n_chk;
  int n_err;
  int exp_ret;

  alu_issue_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU beside the stage.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      OP_PASS: alu_result = alu_a;
      OP_ADD:  alu_result = alu_a + alu_b + W'(alu_cin);
      OP_SUB:  alu_result = alu_a + ~alu_b + W'(alu_cin);
      OP_INC:  alu_result = alu_a + W'(alu_cin);
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOT:  alu_result = ~alu_a;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rf_peek(input int i);
    return dut.u_rf.rf_q[i];
  endfunction

  task automatic ld(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Offers one instruction in IDLE (optionally with a same-cycle load); returns at the EXEC negedge.
  task automatic send(input logic [2:0] op, input logic cin, input logic [1:0] rd,
                      input logic [1:0] ra, input logic [1:0] rb,
                      input logic l_en, input logic [1:0] l_a, input logic [W-1:0] l_d);
    @(negedge clk);
    chk("ready_before_issue", 32'(instr_ready), 32'd1);
    instr = {op, cin, rd, ra, rb};
    instr_valid = 1'b1;
    ld_en = l_en; ld_addr = l_a; ld_data = l_d;
    @(negedge clk);
    instr_valid = 1'b0;
    ld_en = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic         cin;
    logic [1:0]   rd, ra, rb;
    logic [W-1:0] exp_d;
    logic         exp_z;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    n_chk = 0; n_err = 0; exp_ret = 0;
    rst_n = 1'b1; instr_valid = 1'b0; instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; res_ready = 1'b0;

    // Reset asserted between edges.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_rf%0d", i), 32'(rf_peek(i)), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Reset while in EXEC: no writeback, no retire.
    ld(2'd0, 4'd5);
    send(OP_ADD, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
    chk("exec_alu_a", 32'(alu_a), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("mid_rst_retired", 32'(retired), 32'd0);
    chk("mid_rst_rf1", 32'(rf_peek(1)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    chk("post_rst_rf1", 32'(rf_peek(1)), 32'd0);
    chk("post_rst_instr_ready", 32'(instr_ready), 32'd1);

    // Vector table over R0=5, R1=3, R2=0, R3=15.
    ld(2'd0, 4'd5); ld(2'd1, 4'd3); ld(2'd3, 4'd15);
    vecs[0] = '{OP_ADD, 1'b0, 2'd2, 2'd0, 2'd1, 4'd8,  1'b0};
    vecs[1] = '{OP_SUB, 1'b1, 2'd2, 2'd0, 2'd0, 4'd0,  1'b1};
    vecs[2] = '{OP_INC, 1'b1, 2'd2, 2'd3, 2'd0, 4'd0,  1'b1};
    vecs[3] = '{OP_AND, 1'b0, 2'd2, 2'd0, 2'd1, 4'd1,  1'b0};
    vecs[4] = '{OP_OR,  1'b0, 2'd3, 2'd0, 2'd1, 4'd7,  1'b0};
    vecs[5] = '{OP_XOR, 1'b0, 2'd2, 2'd1, 2'd1, 4'd0,  1'b1};
    vecs[6] = '{OP_SUB, 1'b1, 2'd1, 2'd0, 2'd1, 4'd2,  1'b0};
    vecs[7] = '{OP_ADD, 1'b1, 2'd0, 2'd0, 2'd0, 4'd11, 1'b0};
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].op, vecs[i].cin, vecs[i].rd, vecs[i].ra, vecs[i].rb, 1'b0, 2'd0, 4'd0);
      wait_res(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_res_data", i), 32'(res_data), 32'(vecs[i].exp_d));
      chk($sformatf("v%0d_res_zero", i), 32'(res_zero), 32'(vecs[i].exp_z));
      release_res();
      exp_ret++;
      chk($sformatf("v%0d_retired", i), 32'(retired), 32'(exp_ret));
      chk($sformatf("v%0d_rf_rd", i), 32'(rf_peek(int'(vecs[i].rd))), 32'(vecs[i].exp_d));
    end

    // Backpressure: R0=11, R1=2 -> 13 held while a new instruction is offered.
    send(OP_ADD, 1'b0, 2'd3, 2'd0, 2'd1, 1'b0, 2'd0, 4'd0);
    wait_res(lat);
    chk("bp_latency", 32'(lat), 32'd2);
    instr = {OP_XOR, 1'b0, 2'd0, 2'd0, 2'd0};
    instr_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_res_valid", c), 32'(res_valid), 32'd1);
      chk($sformatf("bp%0d_res_data", c), 32'(res_data), 32'd13);
      chk($sformatf("bp%0d_res_zero", c), 32'(res_zero), 32'd0);
      chk($sformatf("bp%0d_instr_ready", c), 32'(instr_ready), 32'd0);
      chk($sformatf("bp%0d_retired", c), 32'(retired), 32'(exp_ret));
    end
    instr_valid = 1'b0;
    release_res();
    exp_ret++;
    chk("bp_retired_once", 32'(retired), 32'(exp_ret));
    chk("bp_idle_after", 32'(instr_ready), 32'd1);
    @(negedge clk);
    chk("bp_no_extra_accept", 32'(res_valid), 32'd0);
    chk("bp_rf3", 32'(rf_peek(3)), 32'd13);
    chk("bp_rf0_intact", 32'(rf_peek(0)), 32'd11);

    // Bypass on accept and load/writeback collision in EXEC.
    ld(2'd0, 4'd5);
    send(OP_ADD, 1'b0, 2'd2, 2'd0, 2'd1, 1'b1, 2'd1, 4'd7);
    chk("byp_alu_b", 32'(alu_b), 32'd7);
    chk("byp_alu_a", 32'(alu_a), 32'd5);
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'd9;
    @(negedge clk);
    ld_en = 1'b0;
    chk("col_res_valid", 32'(res_valid), 32'd1);
    chk("col_res_data", 32'(res_data), 32'd12);
    release_res();
    exp_ret++;
    chk("col_rf2_wb_wins", 32'(rf_peek(2)), 32'd12);
    chk("col_rf1_loaded", 32'(rf_peek(1)), 32'd7);
    chk("col_retired", 32'(retired), 32'(exp_ret));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
